// File: rtl/alu_control_mc_pkg.sv
// Shared encodings for the multi-cycle ALU control block: ALUOp classes,
// R-type function codes, ALU control codes, FSM states and counter sizing.
package alu_control_mc_pkg;

    localparam int ALUOP_W_DEF = 3;
    localparam int FUNC_W_DEF  = 6;
    localparam int CTRL_W_DEF  = 4;
    localparam int COUNT_W     = 8;

    // ALUOp classes from main control
    localparam logic [2:0] ALUOP_ADD   = 3'b000;  // load/store address
    localparam logic [2:0] ALUOP_SUB   = 3'b001;  // branch compare
    localparam logic [2:0] ALUOP_RTYPE = 3'b010;  // decode from Function
    localparam logic [2:0] ALUOP_ANDI  = 3'b011;
    localparam logic [2:0] ALUOP_ADDI  = 3'b100;
    localparam logic [2:0] ALUOP_MUL   = 3'b101;  // multi-cycle
    localparam logic [2:0] ALUOP_ORI   = 3'b110;
    localparam logic [2:0] ALUOP_SLTI  = 3'b111;

    // R-type function field values
    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SRL  = 6'b000010;
    localparam logic [5:0] FN_JR   = 6'b001000;
    localparam logic [5:0] FN_DIV  = 6'b011010;  // multi-cycle
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_XOR  = 6'b100110;
    localparam logic [5:0] FN_NOR  = 6'b100111;
    localparam logic [5:0] FN_SLT  = 6'b101010;

    // ALU control codes
    localparam logic [3:0] CTRL_AND = 4'b0000;
    localparam logic [3:0] CTRL_OR  = 4'b0001;
    localparam logic [3:0] CTRL_ADD = 4'b0010;
    localparam logic [3:0] CTRL_MUL = 4'b0011;
    localparam logic [3:0] CTRL_XOR = 4'b0101;
    localparam logic [3:0] CTRL_SUB = 4'b0110;
    localparam logic [3:0] CTRL_SLT = 4'b0111;
    localparam logic [3:0] CTRL_SLL = 4'b1001;
    localparam logic [3:0] CTRL_SRL = 4'b1010;
    localparam logic [3:0] CTRL_NOR = 4'b1100;
    localparam logic [3:0] CTRL_DIV = 4'b1101;
    localparam logic [3:0] CTRL_JR  = 4'b1111;

    typedef enum logic {ST_IDLE, ST_MULTI} state_t;

    // Counter preload for an op of total latency 'cycles' (issue to ResultValid).
    function automatic logic [COUNT_W-1:0] latency_load(input int cycles);
        return COUNT_W'(cycles - 2);
    endfunction

endpackage

// File: rtl/alu_control_mc_if.sv
// Issue/result bundle between main control (master) and the ALU control block (slave).
interface alu_control_mc_if #(
    parameter int ALUOP_W = 3,
    parameter int FUNC_W  = 6,
    parameter int CTRL_W  = 4
);
    logic               issue_valid;
    logic               issue_ready;
    logic [ALUOP_W-1:0] alu_op;
    logic [FUNC_W-1:0]  func;
    logic               flush;
    logic [CTRL_W-1:0]  control_alu;
    logic               result_valid;
    logic               write_quotient;
    logic               write_remainder;
    logic               jump_reg;
    logic               illegal_op;
    logic               busy;
    logic               stall;

    modport master (
        output issue_valid, alu_op, func, flush,
        input  issue_ready, control_alu, result_valid, write_quotient,
               write_remainder, jump_reg, illegal_op, busy, stall
    );

    modport slave (
        input  issue_valid, alu_op, func, flush,
        output issue_ready, control_alu, result_valid, write_quotient,
               write_remainder, jump_reg, illegal_op, busy, stall
    );
endinterface

// File: rtl/alu_control_decode.sv
// Pure combinational ALUOp/Function decode table with multi-cycle, DIV, JR
// and illegal-function classification.
module alu_control_decode
    import alu_control_mc_pkg::*;
#(
    parameter int ALUOP_W = ALUOP_W_DEF,
    parameter int FUNC_W  = FUNC_W_DEF,
    parameter int CTRL_W  = CTRL_W_DEF
) (
    input  logic [ALUOP_W-1:0] i_alu_op,
    input  logic [FUNC_W-1:0]  i_func,
    output logic [CTRL_W-1:0]  o_code,
    output logic               o_is_multi,
    output logic               o_is_div,
    output logic               o_is_jr,
    output logic               o_illegal
);

    // Table lookup; every output defaulted so no path leaves an X
    always_comb begin
        o_code     = CTRL_W'(CTRL_AND);
        o_is_multi = 1'b0;
        o_is_div   = 1'b0;
        o_is_jr    = 1'b0;
        o_illegal  = 1'b0;
        case (i_alu_op)
            ALUOP_W'(ALUOP_ADD):  o_code = CTRL_W'(CTRL_ADD);
            ALUOP_W'(ALUOP_SUB):  o_code = CTRL_W'(CTRL_SUB);
            ALUOP_W'(ALUOP_ANDI): o_code = CTRL_W'(CTRL_AND);
            ALUOP_W'(ALUOP_ADDI): o_code = CTRL_W'(CTRL_ADD);
            ALUOP_W'(ALUOP_ORI):  o_code = CTRL_W'(CTRL_OR);
            ALUOP_W'(ALUOP_SLTI): o_code = CTRL_W'(CTRL_SLT);
            ALUOP_W'(ALUOP_MUL): begin
                o_code     = CTRL_W'(CTRL_MUL);
                o_is_multi = 1'b1;
            end
            ALUOP_W'(ALUOP_RTYPE): begin
                case (i_func)
                    FUNC_W'(FN_SLL):                   o_code = CTRL_W'(CTRL_SLL);
                    FUNC_W'(FN_SRL):                   o_code = CTRL_W'(CTRL_SRL);
                    FUNC_W'(FN_ADD), FUNC_W'(FN_ADDU): o_code = CTRL_W'(CTRL_ADD);
                    FUNC_W'(FN_SUB), FUNC_W'(FN_SUBU): o_code = CTRL_W'(CTRL_SUB);
                    FUNC_W'(FN_AND):                   o_code = CTRL_W'(CTRL_AND);
                    FUNC_W'(FN_OR):                    o_code = CTRL_W'(CTRL_OR);
                    FUNC_W'(FN_SLT):                   o_code = CTRL_W'(CTRL_SLT);
                    FUNC_W'(FN_XOR):                   o_code = CTRL_W'(CTRL_XOR);
                    FUNC_W'(FN_NOR):                   o_code = CTRL_W'(CTRL_NOR);
                    FUNC_W'(FN_DIV): begin
                        o_code     = CTRL_W'(CTRL_DIV);
                        o_is_multi = 1'b1;
                        o_is_div   = 1'b1;
                    end
                    FUNC_W'(FN_JR): begin
                        o_code  = CTRL_W'(CTRL_JR);
                        o_is_jr = 1'b1;
                    end
                    default: begin
                        o_code    = CTRL_W'(CTRL_AND);
                        o_illegal = 1'b1;
                    end
                endcase
            end
            default: o_code = CTRL_W'(CTRL_AND);
        endcase
    end

endmodule

// File: rtl/alu_control_mc.sv
// Registered ALU control with MUL/DIV sequencing: single-cycle ops complete
// one cycle after issue, multi-cycle ops hold ControlALU and raise Busy/Stall
// until a countdown expires, then pulse ResultValid (plus HI/LO writes for DIV).
module alu_control_mc
    import alu_control_mc_pkg::*;
#(
    parameter int ALUOP_W    = ALUOP_W_DEF,
    parameter int FUNC_W     = FUNC_W_DEF,
    parameter int CTRL_W     = CTRL_W_DEF,
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    alu_control_mc_if.slave  bus
);

    localparam logic [COUNT_W-1:0] MUL_LOAD = latency_load(MUL_CYCLES);
    localparam logic [COUNT_W-1:0] DIV_LOAD = latency_load(DIV_CYCLES);

    state_t               r_state, w_state_next;
    logic [COUNT_W-1:0]   r_count, w_count_next;
    logic [CTRL_W-1:0]    r_ctrl,  w_ctrl_next;
    logic                 r_single_valid, w_single_valid_next;
    logic                 r_jr,      w_jr_next;
    logic                 r_illegal, w_illegal_next;
    logic                 r_is_div,  w_is_div_next;

    logic [CTRL_W-1:0]    w_code;
    logic                 w_is_multi, w_is_div, w_is_jr, w_illegal;
    logic                 w_issue_ready, w_accept, w_multi_done;

    alu_control_decode #(
        .ALUOP_W (ALUOP_W),
        .FUNC_W  (FUNC_W),
        .CTRL_W  (CTRL_W)
    ) u_decode (
        .i_alu_op   (bus.alu_op),
        .i_func     (bus.func),
        .o_code     (w_code),
        .o_is_multi (w_is_multi),
        .o_is_div   (w_is_div),
        .o_is_jr    (w_is_jr),
        .o_illegal  (w_illegal)
    );

    // The completion cycle of a multi-cycle op doubles as an issue slot so
    // back-to-back ops see no bubble; a flush always drops the issue.
    assign w_multi_done  = (r_state == ST_MULTI) && (r_count == '0);
    assign w_issue_ready = (r_state == ST_IDLE) || w_multi_done;
    assign w_accept      = bus.issue_valid && w_issue_ready && !bus.flush;

    // Next-state, countdown and output-register updates
    always_comb begin
        w_state_next        = r_state;
        w_count_next        = r_count;
        w_ctrl_next         = r_ctrl;
        w_single_valid_next = 1'b0;
        w_jr_next           = 1'b0;
        w_illegal_next      = 1'b0;
        w_is_div_next       = r_is_div;
        if ((r_state == ST_MULTI) && bus.flush) begin
            w_state_next = ST_IDLE;
            w_count_next = '0;
        end else if (w_accept) begin
            w_ctrl_next = w_code;
            if (w_is_multi) begin
                w_state_next  = ST_MULTI;
                w_count_next  = w_is_div ? DIV_LOAD : MUL_LOAD;
                w_is_div_next = w_is_div;
            end else begin
                w_state_next        = ST_IDLE;
                w_count_next        = '0;
                w_single_valid_next = 1'b1;
                w_jr_next           = w_is_jr;
                w_illegal_next      = w_illegal;
                w_is_div_next       = 1'b0;
            end
        end else if (r_state == ST_MULTI) begin
            if (r_count == '0) begin
                w_state_next = ST_IDLE;
            end else begin
                w_count_next = r_count - COUNT_W'(1);
            end
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state        <= ST_IDLE;
            r_count        <= '0;
            r_ctrl         <= '0;
            r_single_valid <= 1'b0;
            r_jr           <= 1'b0;
            r_illegal      <= 1'b0;
            r_is_div       <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_count        <= w_count_next;
            r_ctrl         <= w_ctrl_next;
            r_single_valid <= w_single_valid_next;
            r_jr           <= w_jr_next;
            r_illegal      <= w_illegal_next;
            r_is_div       <= w_is_div_next;
        end
    end

    assign bus.issue_ready     = w_issue_ready;
    assign bus.control_alu     = r_ctrl;
    assign bus.result_valid    = r_single_valid || w_multi_done;
    assign bus.write_quotient  = w_multi_done && r_is_div;
    assign bus.write_remainder = w_multi_done && r_is_div;
    assign bus.jump_reg        = r_jr;
    assign bus.illegal_op      = r_illegal;
    assign bus.busy            = (r_state == ST_MULTI);
    assign bus.stall           = (r_state == ST_MULTI);

endmodule

// File: tb/tb_alu_control_mc.sv
// Self-checking bench for alu_control_mc: scoreboard of expected results
// plus per-scenario cycle-accurate checks on a MUL=4/DIV=32 instance and a
// MUL=2/DIV=2 instance.
module tb_alu_control_mc;

    localparam int MUL_L = 4;
    localparam int DIV_L = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_control_mc_if bus  ();
    alu_control_mc_if bus2 ();

    alu_control_mc #(.MUL_CYCLES(MUL_L), .DIV_CYCLES(DIV_L)) dut (
        .i_clk (clk), .i_rst (rst), .bus (bus)
    );

    alu_control_mc #(.MUL_CYCLES(2), .DIV_CYCLES(2)) dut2 (
        .i_clk (clk), .i_rst (rst), .bus (bus2)
    );

    typedef struct {
        int         cyc;
        logic [3:0] ctrl;
        logic       jr;
        logic       ill;
        logic       div;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    // Reference decode table
    function automatic void model(input logic [2:0] op, input logic [5:0] fn,
                                  output logic [3:0] ctrl, output logic jr,
                                  output logic ill, output logic dv, output logic mu);
        jr = 0; ill = 0; dv = 0; mu = 0; ctrl = 4'b0000;
        case (op)
            3'b000: ctrl = 4'b0010;
            3'b001: ctrl = 4'b0110;
            3'b011: ctrl = 4'b0000;
            3'b100: ctrl = 4'b0010;
            3'b101: begin ctrl = 4'b0011; mu = 1; end
            3'b110: ctrl = 4'b0001;
            3'b111: ctrl = 4'b0111;
            default: begin
                case (fn)
                    6'b000000: ctrl = 4'b1001;
                    6'b000010: ctrl = 4'b1010;
                    6'b100000, 6'b100001: ctrl = 4'b0010;
                    6'b100010, 6'b100011: ctrl = 4'b0110;
                    6'b100100: ctrl = 4'b0000;
                    6'b100101: ctrl = 4'b0001;
                    6'b101010: ctrl = 4'b0111;
                    6'b100110: ctrl = 4'b0101;
                    6'b100111: ctrl = 4'b1100;
                    6'b011010: begin ctrl = 4'b1101; mu = 1; dv = 1; end
                    6'b001000: begin ctrl = 4'b1111; jr = 1; end
                    default:   begin ctrl = 4'b0000; ill = 1; end
                endcase
            end
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.issue_valid = 1'b0;
        bus.flush       = 1'b0;
    endtask

    // Present an issue this cycle; when push is set the op is expected to be accepted now
    task automatic present(input logic [2:0] op, input logic [5:0] fn, input bit push);
        logic [3:0] c;
        logic jr, ill, dv, mu;
        bus.issue_valid = 1'b1;
        bus.alu_op      = op;
        bus.func        = fn;
        bus.flush       = 1'b0;
        if (push) begin
            model(op, fn, c, jr, ill, dv, mu);
            sb.push_back('{cyc: cyc + (mu ? (dv ? DIV_L - 1 : MUL_L - 1) : 1),
                           ctrl: c, jr: jr, ill: ill, div: dv});
        end
    endtask

    // Result monitor: every ResultValid pulse must match the oldest expected entry
    always @(negedge clk) begin
        if (sb.size() > 0 && sb[0].cyc < cyc) begin
            checks++; errors++;
            $display("FAIL missed_result: expected ResultValid at cycle %0d, none by cycle %0d", sb[0].cyc, cyc);
            void'(sb.pop_front());
        end
        if (bus.result_valid === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_result: cycle %0d ctrl=%b, none expected", cyc, bus.control_alu);
            end else begin
                mon_e = sb.pop_front();
                $display("txn cycle %0d ctrl=%b jr=%b ill=%b wq=%b wr=%b", cyc, bus.control_alu,
                         bus.jump_reg, bus.illegal_op, bus.write_quotient, bus.write_remainder);
                if (mon_e.cyc !== cyc || bus.control_alu !== mon_e.ctrl || bus.jump_reg !== mon_e.jr ||
                    bus.illegal_op !== mon_e.ill || bus.write_quotient !== mon_e.div ||
                    bus.write_remainder !== mon_e.div) begin
                    errors++;
                    $display("FAIL result_match: got cyc=%0d ctrl=%b jr=%b ill=%b wq=%b wr=%b, expected cyc=%0d ctrl=%b jr=%b ill=%b wq/wr=%b",
                             cyc, bus.control_alu, bus.jump_reg, bus.illegal_op, bus.write_quotient,
                             bus.write_remainder, mon_e.cyc, mon_e.ctrl, mon_e.jr, mon_e.ill, mon_e.div);
                end
            end
        end else if (!rst) begin
            checks++;
            if ({bus.write_quotient, bus.write_remainder, bus.jump_reg, bus.illegal_op} !== 4'b0000) begin
                errors++;
                $display("FAIL strobe_without_valid: cycle %0d wq/wr/jr/ill=%b, expected 0000", cyc,
                         {bus.write_quotient, bus.write_remainder, bus.jump_reg, bus.illegal_op});
            end
        end
    end

    task automatic test_reset();
        tick(); tick();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.control_alu !== 4'b0000) begin
            errors++; $display("FAIL reset_ctrl: got %b expected 0000", bus.control_alu);
        end
        checks++;
        if ({bus.result_valid, bus.write_quotient, bus.write_remainder, bus.jump_reg, bus.illegal_op} !== 5'b0) begin
            errors++; $display("FAIL reset_pulses: got %b expected 00000",
                {bus.result_valid, bus.write_quotient, bus.write_remainder, bus.jump_reg, bus.illegal_op});
        end
        checks++;
        if ({bus.busy, bus.stall} !== 2'b00) begin
            errors++; $display("FAIL reset_busy: got %b expected 00", {bus.busy, bus.stall});
        end
        checks++;
        if (bus.issue_ready !== 1'b1) begin
            errors++; $display("FAIL reset_ready: got %b expected 1", bus.issue_ready);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_ctrl [3];
        logic [5:0] fns [3];
        exp_ctrl[0] = 4'b0010; exp_ctrl[1] = 4'b0110; exp_ctrl[2] = 4'b1111;
        fns[0] = 6'b100000; fns[1] = 6'b100010; fns[2] = 6'b001000;
        tick();
        for (int k = 0; k < 4; k++) begin
            if (k < 3) present(3'b010, fns[k], 1'b1); else idle();
            @(negedge clk);
            if (k > 0) begin
                checks++;
                if (bus.control_alu !== exp_ctrl[k-1] || bus.result_valid !== 1'b1 || bus.jump_reg !== (k == 3)) begin
                    errors++;
                    $display("FAIL b2b_step%0d: ctrl=%b rv=%b jr=%b expected ctrl=%b rv=1 jr=%b",
                             k, bus.control_alu, bus.result_valid, bus.jump_reg, exp_ctrl[k-1], (k == 3));
                end
            end
            tick();
        end
        @(negedge clk);
        checks++;
        if (bus.result_valid !== 1'b0) begin
            errors++; $display("FAIL b2b_end: rv=%b expected 0", bus.result_valid);
        end
    endtask

    task automatic test_div();
        tick();
        present(3'b010, 6'b011010, 1'b1);
        for (int k = 1; k <= DIV_L; k++) begin
            tick();
            if (k >= 5 && k <= 7) present(3'b000, 6'b000000, 1'b0); else idle();
            @(negedge clk);
            checks++;
            if ({bus.busy, bus.stall} !== ((k <= DIV_L - 1) ? 2'b11 : 2'b00)) begin
                errors++; $display("FAIL div_busy_k%0d: got %b", k, {bus.busy, bus.stall});
            end
            checks++;
            if ({bus.result_valid, bus.write_quotient, bus.write_remainder} !== ((k == DIV_L - 1) ? 3'b111 : 3'b000)) begin
                errors++; $display("FAIL div_pulse_k%0d: rv/wq/wr=%b", k,
                                   {bus.result_valid, bus.write_quotient, bus.write_remainder});
            end
            checks++;
            if (bus.issue_ready !== (k >= DIV_L - 1)) begin
                errors++; $display("FAIL div_ready_k%0d: got %b expected %b", k, bus.issue_ready, (k >= DIV_L - 1));
            end
            if (k <= DIV_L - 1) begin
                checks++;
                if (bus.control_alu !== 4'b1101) begin
                    errors++; $display("FAIL div_ctrl_k%0d: got %b expected 1101", k, bus.control_alu);
                end
            end
        end
    endtask

    task automatic test_mul_then_add();
        tick();
        present(3'b101, 6'b000000, 1'b1);
        tick(); idle();
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b1 || bus.issue_ready !== 1'b0) begin
            errors++; $display("FAIL mul_busy: busy=%b ready=%b expected 1/0", bus.busy, bus.issue_ready);
        end
        tick();
        present(3'b000, 6'b000000, 1'b0);   // held while not ready
        tick();
        present(3'b000, 6'b000000, 1'b1);   // accepted in MUL completion cycle
        @(negedge clk);
        checks++;
        if (bus.result_valid !== 1'b1 || bus.control_alu !== 4'b0011 || bus.issue_ready !== 1'b1) begin
            errors++; $display("FAIL mul_done: rv=%b ctrl=%b ready=%b expected 1/0011/1",
                               bus.result_valid, bus.control_alu, bus.issue_ready);
        end
        tick(); idle();
        @(negedge clk);
        checks++;
        if (bus.result_valid !== 1'b1 || bus.control_alu !== 4'b0010 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL add_after_mul: rv=%b ctrl=%b busy=%b expected 1/0010/0",
                               bus.result_valid, bus.control_alu, bus.busy);
        end
    endtask

    task automatic test_flush();
        int rv_seen = 0;
        tick();
        present(3'b010, 6'b011010, 1'b0);
        tick(); idle();
        tick();
        present(3'b000, 6'b000000, 1'b0);
        bus.flush = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++; $display("FAIL flush_pre: busy=%b expected 1", bus.busy);
        end
        tick(); idle();
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.result_valid !== 1'b0 || bus.issue_ready !== 1'b1) begin
            errors++; $display("FAIL flush_idle: busy=%b rv=%b ready=%b expected 0/0/1",
                               bus.busy, bus.result_valid, bus.issue_ready);
        end
        for (int k = 0; k < DIV_L + 4; k++) begin
            tick();
            @(negedge clk);
            if (bus.result_valid === 1'b1) rv_seen++;
        end
        checks++;
        if (rv_seen != 0) begin
            errors++; $display("FAIL flush_no_result: saw %0d ResultValid pulses, expected 0", rv_seen);
        end
        tick();
        present(3'b000, 6'b000000, 1'b1);
        tick(); idle();
        @(negedge clk);
        checks++;
        if (bus.result_valid !== 1'b1 || bus.control_alu !== 4'b0010) begin
            errors++; $display("FAIL flush_next_add: rv=%b ctrl=%b expected 1/0010", bus.result_valid, bus.control_alu);
        end
    endtask

    task automatic test_illegal();
        tick();
        present(3'b010, 6'b111111, 1'b1);
        tick(); idle();
        @(negedge clk);
        checks++;
        if (bus.control_alu !== 4'b0000 || bus.illegal_op !== 1'b1 || bus.result_valid !== 1'b1) begin
            errors++; $display("FAIL illegal: ctrl=%b ill=%b rv=%b expected 0000/1/1",
                               bus.control_alu, bus.illegal_op, bus.result_valid);
        end
        tick();
        @(negedge clk);
        checks++;
        if ({bus.illegal_op, bus.result_valid} !== 2'b00) begin
            errors++; $display("FAIL illegal_end: ill/rv=%b expected 00", {bus.illegal_op, bus.result_valid});
        end
    endtask

    task automatic test_short_latency();
        // MUL_CYCLES=2 then DIV_CYCLES=2 on the second instance
        for (int t = 0; t < 2; t++) begin
            tick();
            bus2.issue_valid = 1'b1;
            bus2.alu_op = (t == 0) ? 3'b101 : 3'b010;
            bus2.func   = (t == 0) ? 6'b000000 : 6'b011010;
            tick();
            bus2.issue_valid = 1'b0;
            @(negedge clk);
            checks++;
            if (bus2.busy !== 1'b1 || bus2.result_valid !== 1'b1 || bus2.write_quotient !== (t == 1) ||
                bus2.control_alu !== ((t == 0) ? 4'b0011 : 4'b1101)) begin
                errors++; $display("FAIL short_op%0d: busy=%b rv=%b wq=%b ctrl=%b", t,
                                   bus2.busy, bus2.result_valid, bus2.write_quotient, bus2.control_alu);
            end
            tick();
            @(negedge clk);
            checks++;
            if ({bus2.busy, bus2.result_valid, bus2.issue_ready} !== 3'b001) begin
                errors++; $display("FAIL short_end%0d: busy/rv/ready=%b expected 001", t,
                                   {bus2.busy, bus2.result_valid, bus2.issue_ready});
            end
        end
    endtask

    task automatic test_reset_mid_div();
        int wq_seen = 0;
        tick();
        present(3'b010, 6'b011010, 1'b0);
        tick(); idle();
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.control_alu, bus.result_valid, bus.write_quotient, bus.write_remainder,
             bus.jump_reg, bus.illegal_op, bus.busy, bus.stall} !== 11'b0 || bus.issue_ready !== 1'b1) begin
            errors++; $display("FAIL reset_mid_div: ctrl=%b rv=%b wq=%b busy=%b ready=%b",
                               bus.control_alu, bus.result_valid, bus.write_quotient, bus.busy, bus.issue_ready);
        end
        for (int k = 0; k < DIV_L + 4; k++) begin
            tick();
            @(negedge clk);
            if (bus.write_quotient === 1'b1) wq_seen++;
        end
        checks++;
        if (wq_seen != 0) begin
            errors++; $display("FAIL reset_no_wq: saw %0d WriteQuotient pulses, expected 0", wq_seen);
        end
    endtask

    task automatic test_random_single();
        logic [2:0] op;
        logic [5:0] fn;
        for (int k = 0; k < 24; k++) begin
            tick();
            if ($urandom_range(0, 3) != 0) begin
                do op = 3'($urandom_range(0, 7)); while (op == 3'b101);
                do fn = 6'($urandom_range(0, 63)); while (fn == 6'b011010);
                present(op, fn, 1'b1);
            end else begin
                idle();
            end
        end
        tick(); idle();
        tick();
        @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++; $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
    endtask

    initial begin
        bus.issue_valid  = 1'b0; bus.alu_op  = '0; bus.func  = '0; bus.flush  = 1'b0;
        bus2.issue_valid = 1'b0; bus2.alu_op = '0; bus2.func = '0; bus2.flush = 1'b0;
        test_reset();
        test_back_to_back();
        test_div();
        test_mul_then_add();
        test_flush();
        test_illegal();
        test_short_latency();
        test_reset_mid_div();
        test_random_single();
        checks++;
        if (sb.size() != 0) begin
            errors++; $display("FAIL final_drain: %0d entries left, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_control_mc.md
Name: alu_control_mc

Overview:
Registered, multi-cycle successor to the single-cycle ALU control decoder. It decodes ALUOp/Function into the ALU control code plus JumpReg/WriteQuotient/WriteRemainder strobes, and sequences variable-latency operations (MUL, DIV). It sits between the main control unit and the ALU/HI-LO register file, and supplies the pipeline stall signal while a long operation is in flight. Operation widths and latencies are parametrised.

Parameters:
ALUOP_W, 3, width of ALUOp from main control
FUNC_W, 6, width of R-type function field
CTRL_W, 4, width of ControlALU
MUL_CYCLES, 4, total latency of MUL from issue to ResultValid (legal range 2..255)
DIV_CYCLES, 32, total latency of DIV from issue to ResultValid (legal range 2..255)

Ports:
Clock  in  1  rising-edge clock
Reset  in  1  synchronous, active-high reset
IssueValid  in  1  operation presented this cycle
IssueReady  out  1  block accepts an issue this cycle
ALUOp  in  ALUOP_W  operation class from main control
Function  in  FUNC_W  R-type function field
Flush  in  1  abort any in-flight multi-cycle op
ControlALU  out  CTRL_W  registered ALU control code, held for the whole op
ResultValid  out  1  one-cycle pulse; ALU result valid this cycle
WriteQuotient  out  1  one-cycle pulse with ResultValid for DIV only
WriteRemainder  out  1  one-cycle pulse with ResultValid for DIV only
JumpReg  out  1  one-cycle pulse with ResultValid for JR
IllegalOp  out  1  one-cycle pulse with ResultValid; undecodable R-type function
Busy  out  1  multi-cycle op in flight
Stall  out  1  freeze upstream stages; equals Busy

Behaviour:
- Decode table (combinational, in sub-module): ALUOp 000->0010, 001->0110, 011->0000, 100->0010, 101->0011 (MUL, multi-cycle), 110->0001, 111->0111. For ALUOp 010 the code comes from Function: 000000->1001, 000010->1010, 100000/100001->0010, 100010/100011->0110, 100100->0000, 100101->0001, 101010->0111, 100110->0101, 100111->1100, 011010->1101 (DIV, multi-cycle), 001000->1111 with JumpReg. Any other Function gives 0000 with IllegalOp=1.
- States: IDLE, MULTI.
- Accept: an issue is accepted when IssueValid && IssueReady. IssueReady = (state==IDLE) || (state==MULTI && Count==0).
- Single-cycle op accepted at edge N: ControlALU, ResultValid, JumpReg and IllegalOp are valid in the cycle after edge N (latency 1). Back-to-back issue every cycle is allowed.
- Multi-cycle op accepted at edge N: ControlALU is loaded at N. Count is loaded with L-2, where L is MUL_CYCLES or DIV_CYCLES, and the state goes to MULTI. Busy and Stall are high from the cycle after N.
- In MULTI, Count decrements each cycle. When Count==0, ResultValid pulses in cycle N+L-1 after the edge; for DIV, WriteQuotient and WriteRemainder pulse with it. In that same cycle IssueReady is high, so a new op can be accepted with no bubble; if none arrives, the next state is IDLE.
- Outputs are held stable during MULTI. Issues presented while IssueReady is low are ignored; the upstream stage holds them.
- Flush: in MULTI it returns the block to IDLE at the next edge, with no ResultValid or write pulses. In IDLE it is a no-op. If Flush and an issue occur in the same cycle, Flush wins and the issue is dropped.
- Reset (any time, including mid-op): state IDLE, Count 0, ControlALU 0000. ResultValid, WriteQuotient, WriteRemainder, JumpReg, IllegalOp, Busy and Stall are all 0. IssueReady is 1 in the first cycle after reset.
- Count width is 8 bits. L=2 loads 0, so ResultValid appears in the cycle after MULTI is entered.
- No X-propagation: every decode branch assigns every output.

Decomposition:
- Shared package: ALUOp encodings, Function encodings, ALU control codes (CTRL_ADD=0010, CTRL_DIV=1101, ...), state enum.
- Sub-module alu_control_decode: pure combinational table. It outputs the code, is_multi, is_div, is_jr and illegal. alu_control_mc instantiates it and owns the FSM, counter and output registers.

Test Plan:
- Reset mid-DIV (3 cycles in, Reset high 1 cycle) -> all outputs 0 the next cycle, IssueReady=1, no WriteQuotient pulse ever.
- Back-to-back ALUOp=010 Func=100000, then 100010, then 001000 on consecutive cycles -> ControlALU 0010, 0110, 1111 on consecutive cycles; ResultValid held high 3 cycles; JumpReg high only in the third.
- DIV issue at cycle 0 with DIV_CYCLES=32 -> Busy/Stall high cycles 1..31; ResultValid, WriteQuotient and WriteRemainder high only in cycle 31; ControlALU=1101 throughout.
- MUL (MUL_CYCLES=4) followed by an ADD issued while IssueReady rises -> ADD accepted in the MUL completion cycle; ADD ResultValid the following cycle; no idle gap.
- Flush at cycle 2 of a DIV, simultaneous with an ADD issue -> IDLE next cycle; no ResultValid from either op; the next ADD issue completes normally.
- ALUOp=010 Func=111111 -> ControlALU 0000, IllegalOp and ResultValid high 1 cycle. With MUL_CYCLES=2 -> ResultValid exactly 1 cycle after the MULTI entry cycle.
